// File: rtl/serial_adder_pkg.sv
// Shared K_ALU types: FSM state encoding, digit width and the flag bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: alu_state_t (IDLE/RUN/DONE), ALU_DIGIT_W, alu_flags_t {c_out, ovf, zero}.
package serial_adder_pkg;

   // Bits consumed per cycle by the serial datapath.
   localparam int ALU_DIGIT_W = 2;

   typedef enum logic [1:0] {
      ALU_IDLE = 2'd0,
      ALU_RUN  = 2'd1,
      ALU_DONE = 2'd2
   } alu_state_t;

   // Same layout as the ALU result/flag register, so it can be passed straight through.
   typedef struct packed {
      logic c_out;
      logic ovf;
      logic zero;
   } alu_flags_t;

endpackage

// File: rtl/serial_adder_add2_slice.sv
// Combinational 2-bit full-adder slice used by the serial adder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none (no handshake).
// Ports: a/b   - 2-bit operand digits; c_in - carry in
//        sum   - 2-bit digit result;   c_out - carry out of the digit
module add2_slice
   import serial_adder_pkg::*;
(
   output logic [ALU_DIGIT_W-1:0] sum,
   output logic                   c_out,
   input  logic [ALU_DIGIT_W-1:0] a,
   input  logic [ALU_DIGIT_W-1:0] b,
   input  logic                   c_in
);

   logic [ALU_DIGIT_W:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{ALU_DIGIT_W{1'b0}}, c_in};
   assign sum   = total[ALU_DIGIT_W-1:0];
   assign c_out = total[ALU_DIGIT_W];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract, two bits per cycle through one add2_slice.
// Latency: out_valid rises N = WIDTH/2 cycles after the accept edge; II = N+2.
// Backpressure: holds result and flags in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b, sub (0 add, 1 subtract);
//        out_valid/out_ready with sum, c_out (1 = no borrow on subtract), ovf (signed), zero.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int N     = WIDTH / ALU_DIGIT_W;
   localparam int CNT_W = $clog2(N);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   alu_flags_t       flags_q, flags_d;

   logic [ALU_DIGIT_W-1:0] slice_sum;
   logic                   slice_co;
   logic [WIDTH-1:0]       shifted_sum;

   add2_slice u_slice (
      .sum   (slice_sum),
      .c_out (slice_co),
      .a     (a_sh_q[ALU_DIGIT_W-1:0]),
      .b     (b_sh_q[ALU_DIGIT_W-1:0]),
      .c_in  (carry_q)
   );

   // Result digits enter at the top, so after N shifts digit 0 sits at the LSB end.
   assign shifted_sum = {slice_sum, sum_q[WIDTH-1:ALU_DIGIT_W]};

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      flags_d = flags_q;

      case (state_q)
         ALU_IDLE: begin
            if (in_valid) begin
               // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
               a_sh_d  = a;
               b_sh_d  = b ^ {WIDTH{sub}};
               carry_d = sub;
               cnt_d   = '0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1] ^ sub;
               state_d = ALU_RUN;
            end
         end
         ALU_RUN: begin
            sum_d   = shifted_sum;
            a_sh_d  = a_sh_q >> ALU_DIGIT_W;
            b_sh_d  = b_sh_q >> ALU_DIGIT_W;
            carry_d = slice_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
               cnt_d         = '0;
               state_d       = ALU_DONE;
               flags_d.c_out = slice_co;
               // Overflow: equal operand signs but the result sign differs from them.
               flags_d.ovf   = (a_msb_q == b_msb_q) && (slice_sum[ALU_DIGIT_W-1] != a_msb_q);
               flags_d.zero  = (shifted_sum == '0);
            end
         end
         ALU_DONE: begin
            if (out_ready) begin
               state_d = ALU_IDLE;
            end
         end
         default: begin
            state_d = ALU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ALU_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         flags_q <= '{c_out: 1'b0, ovf: 1'b0, zero: 1'b1};
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         flags_q <= flags_d;
      end
   end

   assign in_ready  = (state_q == ALU_IDLE);
   assign out_valid = (state_q == ALU_DONE);
   assign sum       = sum_q;
   assign c_out     = flags_q.c_out;
   assign ovf       = flags_q.ovf;
   assign zero      = flags_q.zero;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=32): directed vector table,
// hand-written backpressure / mid-run reset / initiation-interval sequences,
// and 1000 randomized operations against an arithmetic reference model.
module tb_serial_adder;

   localparam int W   = 32;
   localparam int LAT = W / 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          c_out;
   logic          ovf;
   logic          zero;

   int errors = 0;
   int checks = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vsub;
      logic [W-1:0] esum;
      logic         ec;
      logic         eo;
      logic         ez;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                 output logic [W-1:0] rs, output logic rc, output logic ro,
                                 output logic rz);
      logic [W:0] t;
      longint     r;
      if (!ms) begin
         t  = {1'b0, ma} + {1'b0, mb};
         rs = t[W-1:0];
         rc = t[W];
         r  = longint'($signed(ma)) + longint'($signed(mb));
      end else begin
         rs = ma - mb;
         rc = (ma >= mb);
         r  = longint'($signed(ma)) - longint'($signed(mb));
      end
      ro = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      rz = (rs == '0);
   endfunction

   // Accept one operation, wait for the result, stall `stall` cycles, then drain.
   // `junk` toggles in_valid/a/b/sub while the block is busy; it must be ignored.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input int stall, input bit junk,
                        output logic [W-1:0] rs, output logic rc, output logic ro,
                        output logic rz, output int lat);
      int wait_cyc;
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 50) begin
         tick();
         wait_cyc++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 64'(in_ready), 64'd1);
      end
      a        = ta;
      b        = tb;
      sub      = ts;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (junk) begin
            in_valid = 1'($urandom);
            a        = $urandom;
            b        = $urandom;
            sub      = 1'($urandom);
         end
         tick();
         lat++;
      end
      in_valid = 1'b0;
      rs = sum;
      rc = c_out;
      ro = ovf;
      rz = zero;
      for (int i = 0; i < stall; i++) begin
         if (junk) begin
            in_valid = 1'($urandom);
            a        = $urandom;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t         vecs[$];
   logic [W-1:0] rs, es;
   logic         rc, ro, rz, ec, eo, ez;
   int           lat;
   int           acc_at[$];
   int           cyc;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      a         = 32'hDEAD_BEEF;
      b         = 32'h1;
      sub       = 1'b0;

      // ---------------- reset ----------------
      tick();
      tick();
      chk("rst_in_ready_held", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_flags", {61'd0, c_out, ovf, zero}, 64'b001);

      // ---------------- directed table ----------------
      vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         do_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, 0, 1'b0, rs, rc, ro, rz, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
         chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].esum));
         chk($sformatf("vec%0d_c_out", i), 64'(rc), 64'(vecs[i].ec));
         chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].eo));
         chk($sformatf("vec%0d_zero", i), 64'(rz), 64'(vecs[i].ez));
      end
      chk("idle_after_drain", 64'(in_ready), 64'd1);
      chk("sum_held_in_idle", 64'(sum), 64'h2345_6789);

      // ---------------- backpressure ----------------
      a = 32'h11; b = 32'h22; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk("bp_latency", 64'(lat), 64'(LAT));
      for (int i = 0; i < 10; i++) begin
         in_valid = ~in_valid;
         a        = a + 32'h101;
         tick();
         chk("bp_sum_stable", 64'(sum), 64'h33);
         chk("bp_flags_stable", {61'd0, c_out, ovf, zero}, 64'b000);
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
         chk("bp_out_valid_high", 64'(out_valid), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_drain_out_valid", 64'(out_valid), 64'd0);
      chk("bp_drain_in_ready", 64'(in_ready), 64'd1);

      // ---------------- reset mid-RUN ----------------
      a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("midrst_running", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_sum", 64'(sum), 64'd0);
      chk("midrst_zero", 64'(zero), 64'd1);
      do_op(32'h10, 32'h20, 1'b0, 0, 1'b0, rs, rc, ro, rz, lat);
      chk("midrst_next_latency", 64'(lat), 64'(LAT));
      chk("midrst_next_sum", 64'(rs), 64'h30);

      // ---------------- initiation interval with out_ready high ----------------
      a = 32'h5; b = 32'h7; sub = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cyc = 0;
      while (acc_at.size() < 4 && cyc < 200) begin
         if (in_ready) acc_at.push_back(cyc);
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      chk("ii_accept_count", 64'(acc_at.size()), 64'd4);
      for (int i = 1; i < acc_at.size(); i++) begin
         chk($sformatf("ii_%0d", i), 64'(acc_at[i] - acc_at[i-1]), 64'(LAT + 2));
      end
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      chk("ii_return_idle", 64'(in_ready), 64'd1);

      // ---------------- randomized ----------------
      for (int n = 0; n < 1000; n++) begin
         logic [W-1:0] ra, rb;
         logic         rsub;
         ra   = $urandom;
         rb   = $urandom;
         rsub = 1'($urandom);
         case ($urandom_range(0, 7))
            0: ra = 32'h8000_0000;
            1: rb = 32'h7FFF_FFFF;
            2: rb = ra;
            default: ;
         endcase
         model(ra, rb, rsub, es, ec, eo, ez);
         do_op(ra, rb, rsub, $urandom_range(0, 3), 1'b1, rs, rc, ro, rz, lat);
         chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(LAT));
         chk($sformatf("rnd%0d_result", n), {29'd0, rc, ro, rz, rs}, {29'd0, ec, eo, ez, es});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
